// File: rtl/flop_stim_gen_pkg.sv
// Shared types and constants for the flop stimulus generator: FSM states,
// LFSR tap mask, default seed and the LFSR step/seed helpers.
package flop_stim_gen_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT0,
      S_RST_A,
      S_REL_A,
      S_RST_B,
      S_REL_B,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   // Right-shifting Galois step: the bit shifted out folds back through the taps.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

   // An all-zero seed would lock the LFSR, so it is swapped for the default.
   function automatic logic [15:0] seed_fix(input logic [15:0] s);
      return (s == 16'h0000) ? LFSR_DEFAULT_SEED : s;
   endfunction

endpackage

// File: rtl/flop_stim_lfsr.sv
// 16-bit Galois LFSR with seed load and single-step advance enable.
module flop_stim_lfsr
   import flop_stim_gen_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic [15:0] state
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LFSR_DEFAULT_SEED;
      end else if (load) begin
         state <= seed_fix(seed);
      end else if (advance) begin
         state <= lfsr_step(state);
      end
   end

endmodule

// File: rtl/flop_stim_gen.sv
// Drives a randomized reset/data sequence into a flop under test and checks
// its q/qb outputs against an internal one-flop model.
module flop_stim_gen
   import flop_stim_gen_pkg::*;
#(
   parameter int DELAY_W    = 6,
   parameter int DATA_ITERS = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] seed,
   output logic        dut_reset,
   output logic        dut_d,
   input  logic        dut_q,
   input  logic        dut_qb,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  err_count
);

   localparam int IDX_W = (DATA_ITERS > 1) ? $clog2(DATA_ITERS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_ITERS - 1);

   state_t             state;
   logic [DELAY_W-1:0] counter;
   logic [IDX_W-1:0]   data_idx;
   logic [IDX_W-1:0]   idx_inc;
   logic [15:0]        lfsr_state;
   logic               accept;
   logic               expired;
   logic               lfsr_adv;
   logic               chk_valid;
   logic               exp_q;
   logic               mismatch;

   assign accept   = (state == S_IDLE) && start;
   assign expired  = (counter == '0);
   assign idx_inc  = data_idx + 1'b1;
   // Every timed-state entry after WAIT0 consumes one LFSR step; entering DONE does not.
   assign lfsr_adv = expired &&
                     ((state inside {S_WAIT0, S_RST_A, S_REL_A, S_RST_B, S_REL_B}) ||
                      (state == S_DATA && data_idx != LAST_IDX));

   flop_stim_lfsr u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .seed    (seed),
      .advance (lfsr_adv),
      .state   (lfsr_state)
   );

   // NOTE: reset is synchronous and sampled only at the rising edge, so it sits inside the clocked block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         counter   <= '0;
         data_idx  <= '0;
         dut_reset <= 1'b0;
         dut_d     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         chk_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!expired) counter <= counter - 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_WAIT0;
                  counter  <= DELAY_W'(seed_fix(seed));
                  data_idx <= '0;
                  busy     <= 1'b1;
               end
            end
            S_WAIT0: begin
               if (expired) begin
                  state     <= S_RST_A;
                  counter   <= DELAY_W'(lfsr_step(lfsr_state));
                  dut_reset <= 1'b1;
               end
            end
            S_RST_A: begin
               // The first RST_A cycle still shows pre-reset q, so checking starts one cycle later.
               chk_valid <= 1'b1;
               if (expired) begin
                  state     <= S_REL_A;
                  counter   <= DELAY_W'(lfsr_step(lfsr_state));
                  dut_reset <= 1'b0;
                  dut_d     <= 1'b1;
               end
            end
            S_REL_A: begin
               if (expired) begin
                  state     <= S_RST_B;
                  counter   <= DELAY_W'(lfsr_step(lfsr_state));
                  dut_reset <= 1'b1;
               end
            end
            S_RST_B: begin
               if (expired) begin
                  state     <= S_REL_B;
                  counter   <= DELAY_W'(lfsr_step(lfsr_state));
                  dut_reset <= 1'b0;
               end
            end
            S_REL_B: begin
               if (expired) begin
                  state    <= S_DATA;
                  counter  <= DELAY_W'(lfsr_step(lfsr_state));
                  data_idx <= '0;
                  dut_d    <= 1'b0;
               end
            end
            S_DATA: begin
               if (expired) begin
                  if (data_idx == LAST_IDX) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     counter  <= DELAY_W'(lfsr_step(lfsr_state));
                     data_idx <= idx_inc;
                     dut_d    <= idx_inc[0];
                  end
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               chk_valid <= 1'b0;
               dut_d     <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // A bad q and a bad qb in the same cycle still count as a single mismatch.
   assign mismatch = chk_valid && ((dut_q != exp_q) || (dut_qb == dut_q));

   always_ff @(posedge clk) begin
      if (reset) begin
         exp_q     <= 1'b0;
         error     <= 1'b0;
         err_count <= 8'd0;
      end else begin
         exp_q <= dut_reset ? 1'b0 : dut_d;
         if (accept) begin
            error     <= 1'b0;
            err_count <= 8'd0;
         end else if (mismatch) begin
            error <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_flop_stim_gen.sv
// Self-checking bench for flop_stim_gen: a per-cycle expected trace is queued
// at each start and popped against the DUT outputs every cycle.
module tb_flop_stim_gen;

   localparam int DW = 6;
   localparam int NI = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [15:0] seed;
   logic       dut_reset, dut_d, dut_q, dut_qb;
   logic       busy, done, error;
   logic [7:0] err_count;

   int   mode = 0;     // 0: good flop, 1: qb tied to q, 2: q stuck at 1
   logic ff_q = 1'b0;

   typedef struct packed {
      logic       rst;
      logic       d;
      logic       busy;
      logic       done;
      logic       error;
      logic [7:0] cnt;
   } obs_t;

   obs_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   data_start[NI];
   int   m_mode, m_cnt;
   logic m_prev_r, m_prev_d;

   always #5 clk = ~clk;

   // Attached flop under test.
   always @(posedge clk) ff_q <= dut_reset ? 1'b0 : dut_d;
   assign dut_q  = (mode == 2) ? 1'b1 : ff_q;
   assign dut_qb = (mode == 1) ? dut_q : ~dut_q;

   flop_stim_gen #(.DELAY_W(DW), .DATA_ITERS(NI)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .seed      (seed),
      .dut_reset (dut_reset),
      .dut_d     (dut_d),
      .dut_q     (dut_q),
      .dut_qb    (dut_qb),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .err_count (err_count)
   );

   function automatic logic [15:0] step16(input logic [15:0] s);
      logic [15:0] n;
      n = {1'b0, s[15:1]};
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   task automatic add_cycle(input logic r, input logic d, input logic b, input logic dn, input logic chk);
      obs_t o;
      logic eq, q, qb;
      o.rst   = r;
      o.d     = d;
      o.busy  = b;
      o.done  = dn;
      o.error = (m_cnt > 0);
      o.cnt   = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
      eq = m_prev_r ? 1'b0 : m_prev_d;
      q  = (m_mode == 2) ? 1'b1 : eq;
      qb = (m_mode == 1) ? q : ~q;
      if (chk && ((q != eq) || (qb == q))) m_cnt++;
      m_prev_r = r;
      m_prev_d = d;
      sb.push_back(o);
   endtask

   // Expected outputs for every cycle after the start edge, ending with one IDLE cycle.
   task automatic build_trace(input logic [15:0] s, input int md);
      logic [15:0] l;
      int   len;
      logic r, dv;
      m_mode = md; m_cnt = 0; m_prev_r = 1'b0; m_prev_d = 1'b0;
      dv = 1'b0;
      sb.delete();
      l = (s == 16'h0000) ? 16'hACE1 : s;
      for (int st = 0; st < 5 + NI; st++) begin
         if (st > 0) l = step16(l);
         len = int'(l[DW-1:0]) + 1;
         r  = (st == 1 || st == 3);
         dv = (st <= 1) ? 1'b0 : (st <= 4) ? 1'b1 : 1'((st - 5) % 2);
         if (st >= 5) data_start[st-5] = sb.size();
         for (int c = 0; c < len; c++)
            add_cycle(r, dv, 1'b1, 1'b0, !(st == 0 || (st == 1 && c == 0)));
      end
      add_cycle(1'b0, dv, 1'b0, 1'b1, 1'b1);
      add_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_seq(input logic [15:0] sd, input int md, input bit abort, input bit repulse,
                          output int first_rst, output int dones);
      obs_t o, act;
      int   i, abort_at;
      mode = md;
      build_trace(sd, md);
      abort_at = abort ? data_start[2] + 2 : -1;
      first_rst = -1;
      dones = 0;
      seed = sd; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; seed = 16'h5A5A;
      i = 0;
      while (sb.size() > 0) begin
         o   = sb.pop_front();
         act = {dut_reset, dut_d, busy, done, error, err_count};
         n_tests++;
         if (act !== o) begin
            n_fail++;
            $display("FAIL trace seed=%h cycle=%0d: got rst=%b d=%b busy=%b done=%b err=%b cnt=%0d, expected rst=%b d=%b busy=%b done=%b err=%b cnt=%0d",
                     sd, i, act.rst, act.d, act.busy, act.done, act.error, act.cnt,
                     o.rst, o.d, o.busy, o.done, o.error, o.cnt);
         end
         if (dut_reset === 1'b1 && first_rst < 0) first_rst = i;
         if (done === 1'b1) dones++;
         if (i == abort_at) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            sb.delete();
            break;
         end
         if (repulse && (i == 3 || i == 20)) begin
            start = 1'b1; seed = 16'hFFFF;
         end
         @(posedge clk); #1;
         start = 1'b0;
         i++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; seed = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({dut_reset, dut_d, busy, done, error, err_count} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_state: got rst=%b d=%b busy=%b done=%b err=%b cnt=%0d, expected all 0",
                  dut_reset, dut_d, busy, done, error, err_count);
      end
      start = 1'b1; seed = 16'h0001;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_over_start: busy=%b, expected 0", busy);
      end
      @(posedge clk); #1;
      n_tests++;
      if (busy !== 1'b0 || dut_reset !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_over_start_hold: busy=%b rst=%b, expected 0 0", busy, dut_reset);
      end
   endtask

   task automatic test_nominal();
      int fr, dn;
      run_seq(16'h0001, 0, 1'b0, 1'b0, fr, dn);
      n_tests++;
      if (dn != 1) begin
         n_fail++;
         $display("FAIL nominal_done_count: got %0d, expected 1", dn);
      end
      n_tests++;
      if (error !== 1'b0 || err_count !== 8'd0) begin
         n_fail++;
         $display("FAIL nominal_clean: err=%b cnt=%0d, expected 0 0", error, err_count);
      end
   endtask

   task automatic test_seed_zero();
      int fr, dn;
      run_seq(16'h0000, 0, 1'b0, 1'b0, fr, dn);
      n_tests++;
      if (fr != 34) begin
         n_fail++;
         $display("FAIL seed_zero_wait0_len: got %0d, expected 34", fr);
      end
   endtask

   task automatic test_qb_tied();
      int fr, dn, exp_cnt;
      run_seq(16'h0001, 1, 1'b0, 1'b0, fr, dn);
      exp_cnt = (m_cnt > 255) ? 255 : m_cnt;
      n_tests++;
      if (error !== 1'b1 || err_count !== 8'(exp_cnt)) begin
         n_fail++;
         $display("FAIL qb_tied_final: err=%b cnt=%0d, expected 1 %0d", error, err_count, exp_cnt);
      end
   endtask

   task automatic test_stuck_q();
      int fr, dn;
      run_seq(16'h7FFE, 2, 1'b0, 1'b0, fr, dn);
      n_tests++;
      if (error !== 1'b1 || err_count !== 8'd255) begin
         n_fail++;
         $display("FAIL stuck_q_saturate: err=%b cnt=%0d, expected 1 255", error, err_count);
      end
   endtask

   task automatic test_reset_mid_data();
      int fr, dn, late_dones;
      run_seq(16'h0002, 0, 1'b1, 1'b0, fr, dn);
      n_tests++;
      if ({dut_reset, dut_d, busy, done, error, err_count} !== 13'd0) begin
         n_fail++;
         $display("FAIL abort_state: got rst=%b d=%b busy=%b done=%b, expected 0 0 0 0",
                  dut_reset, dut_d, busy, done);
      end
      late_dones = dn;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) late_dones++;
      end
      n_tests++;
      if (late_dones != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d done/busy cycles, expected 0", late_dones);
      end
   endtask

   task automatic test_back_to_back();
      int fr, dn;
      run_seq(16'h1234, 0, 1'b0, 1'b1, fr, dn);
      n_tests++;
      if (dn != 1) begin
         n_fail++;
         $display("FAIL back_to_back_done_count: got %0d, expected 1", dn);
      end
      run_seq(16'hBEEF, 0, 1'b0, 1'b0, fr, dn);
      n_tests++;
      if (dn != 1 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL back_to_back_second: dones=%0d err=%b, expected 1 0", dn, error);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_seed_zero();
      test_qb_tied();
      test_stuck_q();
      test_back_to_back();
      test_reset_mid_data();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
